// File: rtl/sd_decode_pkg.sv
// Shared definitions for the CADR source/destination decode stage:
// IR field positions, legacy functional source/destination codes,
// class encoding and the OA-modification FSM state type.
package sd_decode_pkg;

  // IR field positions
  localparam int unsigned CLASS_LSB      = 43;
  localparam int unsigned FUNCT_LSB      = 10;
  localparam int unsigned SPEC_BIT       = 8;
  localparam int unsigned ALUOP_LSB      = 3;
  localparam int unsigned MSRC_EN_BIT    = 31;
  localparam int unsigned MSRC_LSB       = 26;
  localparam int unsigned DEST_NOT_M_BIT = 25;
  localparam int unsigned DEST_FN_BIT    = 23;
  localparam int unsigned DEST_SEL_BIT   = 22;
  localparam int unsigned MDST_LSB       = 19;

  // OA register layout: low half overlays ir[25:0], high half ir[47:26]
  localparam int unsigned OA_LO_W = 26;
  localparam int unsigned OA_HI_W = 22;
  localparam int unsigned OA_W    = OA_LO_W + OA_HI_W;

  localparam int unsigned NUM_DST_CODES = 16;

  // Legacy functional source codes
  localparam int unsigned MSRC_DC      = 0;
  localparam int unsigned MSRC_SPC     = 1;
  localparam int unsigned MSRC_PDLPTR  = 2;
  localparam int unsigned MSRC_PDLIDX  = 3;
  localparam int unsigned MSRC_PDLTOP  = 4;
  localparam int unsigned MSRC_OPC     = 5;
  localparam int unsigned MSRC_Q       = 6;
  localparam int unsigned MSRC_VMA     = 8;
  localparam int unsigned MSRC_MAP     = 9;
  localparam int unsigned MSRC_MD      = 10;
  localparam int unsigned MSRC_LC      = 11;
  localparam int unsigned MSRC_SPCPOP  = 12;

  // Legacy functional destination codes
  localparam int unsigned MDST_LC      = 1;
  localparam int unsigned MDST_INTCTL  = 2;
  localparam int unsigned MDST_PDLTOP  = 8;
  localparam int unsigned MDST_PDL_P   = 9;
  localparam int unsigned MDST_PDL_X   = 10;
  localparam int unsigned MDST_PDLX    = 11;
  localparam int unsigned MDST_PDLP    = 12;
  localparam int unsigned MDST_SPC     = 13;
  localparam int unsigned MDST_IMOD0   = 14;
  localparam int unsigned MDST_IMOD1   = 15;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_JUMP = 2'd1,
    CLS_DISP = 2'd2,
    CLS_BYTE = 2'd3
  } cls_e;

  typedef enum logic [1:0] {
    OA_IDLE  = 2'd0,
    OA_WAIT  = 2'd1,
    OA_ARMED = 2'd2
  } oa_state_e;

endpackage

// File: rtl/sd_decode_if.sv
// Bus bundle for sd_decode_pipe: IR intake handshake, OA write port,
// flush, and the decoded-word output handshake.
// master: upstream/downstream driver side; slave: the decode stage.
interface sd_decode_if #(
  parameter int unsigned IR_W       = 49,
  parameter int unsigned MSRC_SEL_W = 4
);
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [IR_W-1:0]             in_ir;
  logic                        in_nop;
  logic                        idebug;
  logic                        iwrited;
  logic                        oa_wr_lo;
  logic                        oa_wr_hi;
  logic [25:0]                 oa_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [IR_W-1:0]             out_ir;
  logic [3:0]                  out_class;
  logic [3:0]                  out_funct;
  logic                        out_mul;
  logic                        out_div;
  logic [2**MSRC_SEL_W-1:0]    out_msrc;
  logic                        out_dest;
  logic                        out_destm;
  logic                        out_destvma;
  logic                        out_destmdr;
  logic [15:0]                 out_mdst;
  logic                        out_imod;
  logic                        oa_wait;

  modport master (
    output flush, in_valid, in_ir, in_nop, idebug, iwrited,
           oa_wr_lo, oa_wr_hi, oa_data, out_ready,
    input  in_ready, out_valid, out_ir, out_class, out_funct, out_mul,
           out_div, out_msrc, out_dest, out_destm, out_destvma,
           out_destmdr, out_mdst, out_imod, oa_wait
  );

  modport slave (
    input  flush, in_valid, in_ir, in_nop, idebug, iwrited,
           oa_wr_lo, oa_wr_hi, oa_data, out_ready,
    output in_ready, out_valid, out_ir, out_class, out_funct, out_mul,
           out_div, out_msrc, out_dest, out_destm, out_destvma,
           out_destmdr, out_mdst, out_imod, oa_wait
  );
endinterface

// File: rtl/sd_decode_comb.sv
// Pure combinational decode of a (possibly OA-merged) microinstruction.
// Ports: m = merged IR, nop = suppress all strobes;
// outputs are one-hot class/funct/msrc/mdst plus special-ALU and
// destination class strobes.
module sd_decode_comb
  import sd_decode_pkg::*;
#(
  parameter int unsigned IR_W       = 49,
  parameter int unsigned MSRC_SEL_W = 4,
  parameter int unsigned NUM_MSRC   = 13,
  parameter int unsigned NUM_MDST   = 16
) (
  input  logic [IR_W-1:0]            m,
  input  logic                       nop,
  output logic [3:0]                 cls_c,
  output logic [3:0]                 funct_c,
  output logic                       mul_c,
  output logic                       div_c,
  output logic [2**MSRC_SEL_W-1:0]   msrc_c,
  output logic                       dest_c,
  output logic                       destm_c,
  output logic                       destvma_c,
  output logic                       destmdr_c,
  output logic [NUM_DST_CODES-1:0]   mdst_c
);

  cls_e                  cls;
  logic [MSRC_SEL_W-1:0] msrc_idx;
  logic [3:0]            mdst_idx;
  logic                  alu_op;
  logic                  byte_op;
  logic                  unused_bits;

  // Only selected fields are decoded; the rest of the word passes through.
  assign unused_bits = ^m;

  always_comb begin
    cls       = cls_e'(m[CLASS_LSB +: 2]);
    msrc_idx  = m[MSRC_LSB +: MSRC_SEL_W];
    mdst_idx  = {m[DEST_SEL_BIT], m[MDST_LSB +: 3]};
    alu_op    = (cls == CLS_ALU);
    byte_op   = (cls == CLS_BYTE);
    cls_c     = '0;
    funct_c   = '0;
    mul_c     = 1'b0;
    div_c     = 1'b0;
    msrc_c    = '0;
    dest_c    = 1'b0;
    destm_c   = 1'b0;
    destvma_c = 1'b0;
    destmdr_c = 1'b0;
    mdst_c    = '0;
    if (!nop) begin
      cls_c[m[CLASS_LSB +: 2]]   = 1'b1;
      funct_c[m[FUNCT_LSB +: 2]] = 1'b1;
      mul_c = alu_op & m[SPEC_BIT] & (m[ALUOP_LSB +: 2] == 2'b00);
      div_c = alu_op & m[SPEC_BIT] & (m[ALUOP_LSB +: 2] != 2'b00);
      // Unimplemented source codes decode to nothing
      if (m[MSRC_EN_BIT] && (32'(msrc_idx) < NUM_MSRC))
        msrc_c[msrc_idx] = 1'b1;
      dest_c    = alu_op | byte_op;
      destm_c   = dest_c & ~m[DEST_NOT_M_BIT];
      destvma_c = destm_c & m[DEST_FN_BIT] & ~m[DEST_SEL_BIT];
      destmdr_c = destm_c & m[DEST_FN_BIT] & m[DEST_SEL_BIT];
      if (destm_c && !m[DEST_FN_BIT] && (32'(mdst_idx) < NUM_MDST))
        mdst_c[mdst_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/sd_decode_pipe.sv
// Registered source/destination/op decode stage with OA (imod) merge.
// Ports: clk, reset_n (async active-low), bus (sd_decode_if.slave):
// IR intake handshake, OA write port, flush, decoded output handshake.
// One-cycle latency; intake stalls while an OA write is outstanding.
module sd_decode_pipe
  import sd_decode_pkg::*;
#(
  parameter int unsigned IR_W       = 49,
  parameter int unsigned MSRC_SEL_W = 4,
  parameter int unsigned NUM_MSRC   = 13,
  parameter int unsigned NUM_MDST   = 16
) (
  input logic        clk,
  input logic        reset_n,
  sd_decode_if.slave bus
);

  localparam int unsigned MSRC_N = 2**MSRC_SEL_W;

  oa_state_e                  state, state_n;
  logic [1:0]                 pend, pend_n;
  logic [OA_W-1:0]            oa_reg, oa_reg_n, oa_upd_c;
  logic                       accept_c, merge_c, oa_write_c, imod_c;
  logic [IR_W-1:0]            m_c;
  logic [3:0]                 cls_c, funct_c;
  logic                       mul_c, div_c;
  logic [MSRC_N-1:0]          msrc_c;
  logic                       dest_c, destm_c, destvma_c, destmdr_c;
  logic [NUM_DST_CODES-1:0]   mdst_c;

  assign bus.in_ready = ~bus.oa_wait & ~bus.flush & (~bus.out_valid | bus.out_ready);
  assign accept_c     = bus.in_valid & bus.in_ready;

  // OA bits only apply to the first real word after the writes complete
  assign merge_c = (state == OA_ARMED) & ~bus.in_nop;
  assign m_c     = merge_c ? (bus.in_ir | IR_W'(oa_reg)) : bus.in_ir;

  sd_decode_comb #(
    .IR_W       (IR_W),
    .MSRC_SEL_W (MSRC_SEL_W),
    .NUM_MSRC   (NUM_MSRC),
    .NUM_MDST   (NUM_MDST)
  ) u_comb (
    .m         (m_c),
    .nop       (bus.in_nop),
    .cls_c     (cls_c),
    .funct_c   (funct_c),
    .mul_c     (mul_c),
    .div_c     (div_c),
    .msrc_c    (msrc_c),
    .dest_c    (dest_c),
    .destm_c   (destm_c),
    .destvma_c (destvma_c),
    .destmdr_c (destmdr_c),
    .mdst_c    (mdst_c)
  );

  // mdst is already zero for NOPs, so this only fires on real words
  assign oa_write_c = mdst_c[MDST_IMOD0] | mdst_c[MDST_IMOD1];
  assign imod_c     = merge_c | oa_write_c | bus.idebug | bus.iwrited;

  // OA register with this cycle's half-writes ORed in
  always_comb begin
    oa_upd_c = oa_reg;
    if (bus.oa_wr_lo)
      oa_upd_c[OA_LO_W-1:0] = oa_upd_c[OA_LO_W-1:0] | bus.oa_data;
    if (bus.oa_wr_hi)
      oa_upd_c[OA_W-1:OA_LO_W] = oa_upd_c[OA_W-1:OA_LO_W] | bus.oa_data[OA_HI_W-1:0];
  end

  // OA FSM next-state
  always_comb begin
    state_n  = state;
    pend_n   = pend;
    oa_reg_n = oa_reg;
    case (state)
      OA_IDLE: begin
        if (accept_c && oa_write_c) begin
          pend_n  = {mdst_c[MDST_IMOD1], mdst_c[MDST_IMOD0]};
          state_n = OA_WAIT;
        end
      end
      OA_WAIT: begin
        oa_reg_n = oa_upd_c;
        if (bus.oa_wr_lo) pend_n[0] = 1'b0;
        if (bus.oa_wr_hi) pend_n[1] = 1'b0;
        if (pend_n == 2'b00) state_n = OA_ARMED;
      end
      OA_ARMED: begin
        oa_reg_n = oa_upd_c;
        if (accept_c && !bus.in_nop) begin
          // Merge consumed; a word that itself writes OA starts a fresh wait
          oa_reg_n = '0;
          if (oa_write_c) begin
            pend_n  = {mdst_c[MDST_IMOD1], mdst_c[MDST_IMOD0]};
            state_n = OA_WAIT;
          end else begin
            state_n = OA_IDLE;
          end
        end
      end
      default: state_n = OA_IDLE;
    endcase
    if (bus.flush) begin
      state_n  = OA_IDLE;
      pend_n   = 2'b00;
      oa_reg_n = '0;
    end
  end

  // OA FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= OA_IDLE;
      pend        <= 2'b00;
      oa_reg      <= '0;
      bus.oa_wait <= 1'b0;
    end else begin
      state       <= state_n;
      pend        <= pend_n;
      oa_reg      <= oa_reg_n;
      bus.oa_wait <= (state_n == OA_WAIT);
    end
  end

  // Output register: load on accept, hold under backpressure
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_ir      <= '0;
      bus.out_class   <= '0;
      bus.out_funct   <= '0;
      bus.out_mul     <= 1'b0;
      bus.out_div     <= 1'b0;
      bus.out_msrc    <= '0;
      bus.out_dest    <= 1'b0;
      bus.out_destm   <= 1'b0;
      bus.out_destvma <= 1'b0;
      bus.out_destmdr <= 1'b0;
      bus.out_mdst    <= '0;
      bus.out_imod    <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept_c) begin
      bus.out_valid   <= 1'b1;
      bus.out_ir      <= m_c;
      bus.out_class   <= cls_c;
      bus.out_funct   <= funct_c;
      bus.out_mul     <= mul_c;
      bus.out_div     <= div_c;
      bus.out_msrc    <= msrc_c;
      bus.out_dest    <= dest_c;
      bus.out_destm   <= destm_c;
      bus.out_destvma <= destvma_c;
      bus.out_destmdr <= destmdr_c;
      bus.out_mdst    <= mdst_c;
      bus.out_imod    <= imod_c;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
